fifo_bank_seq: RTL and testbench

Sequencer for a bank of `NUM_FIFOS` identical FIFOs. It runs in two phases. In the fill phase it steers a single input stream into the FIFOs one at a time, `DEPTH` entries each. In the drain phase it pops every FIFO in lockstep so the downstream datapath (e.g. a MAC array) receives one column of `NUM_FIFOS` words per cycle. It sits between the memory-read stream and the FIFO bank and owns every `wren`/`rden` strobe of the bank.

---
 rtl/fifo_bank_seq.sv | 153 +++++++++++++++
 tb/tb_fifo_bank_seq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_bank_seq.sv
// -----------------------------------------------------------------------------
// fifo_bank_seq
//
// Fill/drain sequencer for a bank of NUM_FIFOS identical FIFOs.
//   FILL  : steers one input stream into FIFO 0, 1, ... NUM_FIFOS-1,
//           DEPTH words each, one word per accepted beat.
//   DRAIN : pops every FIFO in lockstep so the consumer sees one column of
//           NUM_FIFOS words per fire.
//   FLUSH : single idle cycle covering the bank's registered read latency.
//   DONE  : one-cycle completion pulse, then back to IDLE.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   start               begin a job; only looked at in IDLE
//   in_valid/in_data    input stream; in_ready is the accept handshake
//   fifo_wren           one-hot write strobe into the bank (bit i -> FIFO i)
//   fifo_wdata          shared write data, always equal to in_data
//   fifo_full/empty     status flags from the bank
//   fifo_rden           read strobes, all bits identical
//   drain_ready         consumer can take a column this cycle
//   drain_valid         bank output registers hold a valid column
//   busy                job in progress (state != IDLE)
//   done                one-cycle pulse at job end
// -----------------------------------------------------------------------------
module fifo_bank_seq #(
  parameter int NUM_FIFOS  = 8,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [NUM_FIFOS-1:0]  fifo_wren,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic [NUM_FIFOS-1:0]  fifo_full,
  input  logic [NUM_FIFOS-1:0]  fifo_empty,
  output logic [NUM_FIFOS-1:0]  fifo_rden,
  input  logic                  drain_ready,
  output logic                  drain_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int SEL_W = $clog2(NUM_FIFOS);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_FIFOS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             fire;

  // Handshake and strobe decode. Everything here is a pure function of the
  // current state and the inputs, so strobes land in the same cycle as the
  // accept/fire decision.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves a signal unassigned would infer a latch.
    in_ready  = 1'b0;
    accept    = 1'b0;
    fire      = 1'b0;
    fifo_wren = '0;

    if (state == S_FILL) begin
      in_ready = !fifo_full[sel];
      accept   = in_valid && in_ready;
    end

    if (accept) begin
      fifo_wren[sel] = 1'b1;
    end

    fire = (state == S_DRAIN) && drain_ready && !(|fifo_empty);
  end

  // Lockstep pop: every FIFO is read together or not at all.
  assign fifo_rden  = {NUM_FIFOS{fire}};
  assign fifo_wdata = in_data;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      state       <= S_IDLE;
      sel         <= '0;
      cnt         <= '0;
      drain_valid <= 1'b0;
    end else begin
      // The bank updates its output registers on the same edge that sees
      // rden, so valid simply follows the strobe by one cycle.
      drain_valid <= fifo_rden[0];

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FILL;
            sel   <= '0;
            cnt   <= '0;
          end
        end

        S_FILL: begin
          if (accept) begin
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              // sel stays on the last FIFO when the fill completes; it is
              // cleared again on the next entry to FILL.
              if (sel == SEL_LAST) begin
                state <= S_DRAIN;
              end else begin
                sel <= sel + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_DRAIN: begin
          if (fire) begin
            if (cnt == CNT_LAST) begin
              state <= S_FLUSH;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_FLUSH: state <= S_DONE;

        S_DONE:  state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_bank_seq.sv
// -----------------------------------------------------------------------------
// tb_fifo_bank_seq
//
// Self-checking bench for fifo_bank_seq at default parameters. A behavioural
// FIFO bank (registered read port) sits on the strobes. Expected writes and
// expected drain columns are queued when a job's stimulus is prepared and are
// popped by a negedge monitor whenever the DUT writes or presents a column.
// Each scenario task also logs per-cycle activity and compares it against
// cycle windows derived from the job timeline.
// -----------------------------------------------------------------------------
module tb_fifo_bank_seq;

  localparam int NF = 8;
  localparam int D  = 8;
  localparam int W  = 8;
  localparam int NW = NF * D;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          drain_ready = 1'b1;
  logic          in_ready;
  logic [NF-1:0] fifo_wren;
  logic [W-1:0]  fifo_wdata;
  logic [NF-1:0] fifo_full;
  logic [NF-1:0] fifo_empty;
  logic [NF-1:0] fifo_rden;
  logic          drain_valid;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_bank_seq #(.NUM_FIFOS(NF), .DEPTH(D), .DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fifo_wren  (fifo_wren),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_rden  (fifo_rden),
    .drain_ready(drain_ready),
    .drain_valid(drain_valid),
    .busy       (busy),
    .done       (done)
  );

  // ---------------------------------------------------------------------------
  // Behavioural FIFO bank with a registered output per FIFO.
  // ---------------------------------------------------------------------------
  logic [W-1:0]  mem    [NF][D];
  logic [2:0]    wp     [NF];
  logic [2:0]    rp     [NF];
  logic [3:0]    count  [NF];
  logic [W-1:0]  o_data [NF];
  logic [NF-1:0] force_full = '0;

  always_comb begin
    fifo_full  = '0;
    fifo_empty = '0;
    for (int i = 0; i < NF; i++) begin
      fifo_full[i]  = (count[i] == 4'(D)) || force_full[i];
      fifo_empty[i] = (count[i] == 4'd0);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NF; i++) begin
      if (!rst_n) begin
        wp[i]     <= '0;
        rp[i]     <= '0;
        count[i]  <= '0;
        o_data[i] <= '0;
      end else begin
        if (fifo_wren[i] && count[i] != 4'(D)) begin
          mem[i][wp[i]] <= fifo_wdata;
          wp[i]         <= wp[i] + 3'd1;
        end
        if (fifo_rden[i] && count[i] != 4'd0) begin
          o_data[i] <= mem[i][rp[i]];
          rp[i]     <= rp[i] + 3'd1;
        end
        count[i] <= count[i]
                  + ((fifo_wren[i] && count[i] != 4'(D)) ? 4'd1 : 4'd0)
                  - ((fifo_rden[i] && count[i] != 4'd0)  ? 4'd1 : 4'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [NF-1:0] wren;
    logic [W-1:0]  data;
  } wr_t;

  wr_t             wr_q[$];
  logic [NF*W-1:0] col_q[$];
  logic            sb_en = 1'b0;

  wr_t             mon_wr;
  logic [NF*W-1:0] mon_col;
  logic [NF*W-1:0] mon_obs;

  always @(negedge clk) begin
    if (sb_en) begin
      checks++;
      if ((|fifo_wren) && (|fifo_rden)) begin
        errors++;
        $display("FAIL strobe_overlap: wren=%b rden=%b, want one of them zero", fifo_wren, fifo_rden);
      end
      if (|fifo_wren) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL extra_write: wren=%b data=%h, want no write", fifo_wren, fifo_wdata);
        end else begin
          mon_wr = wr_q.pop_front();
          if (fifo_wren !== mon_wr.wren || fifo_wdata !== mon_wr.data) begin
            errors++;
            $display("FAIL write: got wren=%b data=%h, want wren=%b data=%h",
                     fifo_wren, fifo_wdata, mon_wr.wren, mon_wr.data);
          end
        end
      end
      if (drain_valid) begin
        checks++;
        for (int i = 0; i < NF; i++) mon_obs[i*W +: W] = o_data[i];
        if (col_q.size() == 0) begin
          errors++;
          $display("FAIL extra_column: got %h, want no column", mon_obs);
        end else begin
          mon_col = col_q.pop_front();
          if (mon_obs !== mon_col) begin
            errors++;
            $display("FAIL column: got %h want %h", mon_obs, mon_col);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Job driver. Cycle c counts from the cycle in which start is driven.
  // ---------------------------------------------------------------------------
  logic [255:0] ir_log, wr_log, rd_log, dv_log, bz_log, dn_log;

  function automatic logic [255:0] span(input int a, input int b);
    logic [255:0] m;
    m = '0;
    for (int c = a; c <= b; c++) m[c] = 1'b1;
    return m;
  endfunction

  task automatic run_job(input logic [W-1:0] base, input bit bubbles, input int full_at,
                         input int stall_at, input bit spurious, input int rst_at,
                         output int done_c);
    int              idx;
    wr_t             w;
    logic [NF*W-1:0] col;
    idx    = 0;
    done_c = -1;
    ir_log = '0; wr_log = '0; rd_log = '0;
    dv_log = '0; bz_log = '0; dn_log = '0;
    for (int j = 0; j < NW; j++) begin
      w.wren = NF'(1) << (j / D);
      w.data = base + W'(j);
      wr_q.push_back(w);
    end
    for (int k = 0; k < D; k++) begin
      for (int i = 0; i < NF; i++) col[i*W +: W] = base + W'(i * D + k);
      col_q.push_back(col);
    end
    @(posedge clk); #1;
    sb_en = 1'b1;
    for (int c = 0; c < 250; c++) begin
      start       = (c == 0) || (spurious && (c == 10 || c == 68));
      in_valid    = (c >= 1) && (idx < NW || spurious) && (!bubbles || (c % 2 == 0));
      in_data     = (idx < NW) ? base + W'(idx) : 8'hEE;
      force_full  = (full_at >= 0 && c >= full_at && c < full_at + 2) ? NF'(1) << (idx / D) : '0;
      drain_ready = !(stall_at >= 0 && c >= stall_at && c < stall_at + 3);
      rst_n       = !(c == rst_at);
      @(negedge clk);
      ir_log[c] = in_ready;
      wr_log[c] = |fifo_wren;
      rd_log[c] = |fifo_rden;
      dv_log[c] = drain_valid;
      bz_log[c] = busy;
      dn_log[c] = done;
      if (done && done_c < 0) done_c = c;
      if (in_valid && in_ready) idx++;
      if ((done_c >= 0 && c == done_c + 1) || (rst_at >= 0 && c == rst_at + 2)) break;
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0; force_full = '0; drain_ready = 1'b1; rst_n = 1'b1;
    sb_en = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (fifo_wren !== '0)     begin errors++; $display("FAIL rst_wren: got %b want 0", fifo_wren); end
    checks++; if (fifo_rden !== '0)     begin errors++; $display("FAIL rst_rden: got %b want 0", fifo_rden); end
    checks++; if (drain_valid !== 1'b0) begin errors++; $display("FAIL rst_drain_valid: got %b want 0", drain_valid); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)        begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (fifo_wdata !== 8'hA5) begin errors++; $display("FAIL rst_wdata: got %h want a5", fifo_wdata); end
    in_data = 8'h3C;
    #1;
    checks++; if (fifo_wdata !== 8'h3C) begin errors++; $display("FAIL wdata_follow: got %h want 3c", fifo_wdata); end
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_rst: busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int dc;
    run_job(8'h00, 1'b0, -1, -1, 1'b0, -1, dc);
    checks++; if (dc != 74) begin errors++; $display("FAIL basic_done_cycle: got %0d want 74", dc); end
    checks++; if (bz_log !== span(1, 74))  begin errors++; $display("FAIL basic_busy: got %h want %h", bz_log, span(1, 74)); end
    checks++; if (ir_log !== span(1, 64))  begin errors++; $display("FAIL basic_in_ready: got %h want %h", ir_log, span(1, 64)); end
    checks++; if (wr_log !== span(1, 64))  begin errors++; $display("FAIL basic_wren: got %h want %h", wr_log, span(1, 64)); end
    checks++; if (rd_log !== span(65, 72)) begin errors++; $display("FAIL basic_rden: got %h want %h", rd_log, span(65, 72)); end
    checks++; if (dv_log !== span(66, 73)) begin errors++; $display("FAIL basic_drain_valid: got %h want %h", dv_log, span(66, 73)); end
    checks++; if (dn_log !== span(74, 74)) begin errors++; $display("FAIL basic_done: got %h want %h", dn_log, span(74, 74)); end
    checks++; if (wr_q.size() != 0 || col_q.size() != 0) begin
      errors++; $display("FAIL basic_leftover: writes=%0d columns=%0d want 0 0", wr_q.size(), col_q.size());
    end
  endtask

  task automatic test_bubbles();
    int dc;
    logic [255:0] exp_wr;
    exp_wr = '0;
    for (int c = 2; c <= 128; c += 2) exp_wr[c] = 1'b1;
    run_job(8'h40, 1'b1, -1, -1, 1'b0, -1, dc);
    checks++; if (dc != 138) begin errors++; $display("FAIL bub_done_cycle: got %0d want 138", dc); end
    checks++; if (ir_log !== span(1, 128))   begin errors++; $display("FAIL bub_fill_len: got %h want %h", ir_log, span(1, 128)); end
    checks++; if (wr_log !== exp_wr)         begin errors++; $display("FAIL bub_wren: got %h want %h", wr_log, exp_wr); end
    checks++; if (rd_log !== span(129, 136)) begin errors++; $display("FAIL bub_rden: got %h want %h", rd_log, span(129, 136)); end
    checks++; if (dv_log !== span(130, 137)) begin errors++; $display("FAIL bub_drain_valid: got %h want %h", dv_log, span(130, 137)); end
    checks++; if (wr_q.size() != 0 || col_q.size() != 0) begin
      errors++; $display("FAIL bub_leftover: writes=%0d columns=%0d want 0 0", wr_q.size(), col_q.size());
    end
  endtask

  task automatic test_backpressure();
    int dc;
    run_job(8'h80, 1'b0, -1, 67, 1'b0, -1, dc);
    checks++; if (dc != 77) begin errors++; $display("FAIL bp_done_cycle: got %0d want 77", dc); end
    checks++; if (rd_log !== (span(65, 66) | span(70, 75))) begin
      errors++; $display("FAIL bp_rden: got %h want %h", rd_log, span(65, 66) | span(70, 75));
    end
    checks++; if ($countones(rd_log) != 8) begin errors++; $display("FAIL bp_fires: got %0d want 8", $countones(rd_log)); end
    checks++; if (dv_log !== (span(66, 67) | span(71, 76))) begin
      errors++; $display("FAIL bp_drain_valid: got %h want %h", dv_log, span(66, 67) | span(71, 76));
    end
    checks++; if (bz_log !== span(1, 77)) begin errors++; $display("FAIL bp_busy: got %h want %h", bz_log, span(1, 77)); end
    checks++; if (wr_q.size() != 0 || col_q.size() != 0) begin
      errors++; $display("FAIL bp_leftover: writes=%0d columns=%0d want 0 0", wr_q.size(), col_q.size());
    end
  endtask

  task automatic test_spurious();
    int dc;
    run_job(8'hC3, 1'b0, -1, -1, 1'b1, -1, dc);
    checks++; if (dc != 74) begin errors++; $display("FAIL spur_done_cycle: got %0d want 74", dc); end
    checks++; if (ir_log !== span(1, 64))  begin errors++; $display("FAIL spur_in_ready: got %h want %h", ir_log, span(1, 64)); end
    checks++; if (wr_log !== span(1, 64))  begin errors++; $display("FAIL spur_wren: got %h want %h", wr_log, span(1, 64)); end
    checks++; if (rd_log !== span(65, 72)) begin errors++; $display("FAIL spur_rden: got %h want %h", rd_log, span(65, 72)); end
    checks++; if (wr_q.size() != 0 || col_q.size() != 0) begin
      errors++; $display("FAIL spur_leftover: writes=%0d columns=%0d want 0 0", wr_q.size(), col_q.size());
    end
  endtask

  task automatic test_full_guard();
    int dc;
    run_job(8'h11, 1'b0, 20, -1, 1'b0, -1, dc);
    checks++; if (ir_log !== (span(1, 19) | span(22, 66))) begin
      errors++; $display("FAIL full_in_ready: got %h want %h", ir_log, span(1, 19) | span(22, 66));
    end
    checks++; if (wr_log !== (span(1, 19) | span(22, 66))) begin
      errors++; $display("FAIL full_wren: got %h want %h", wr_log, span(1, 19) | span(22, 66));
    end
    checks++; if (dv_log !== span(68, 75)) begin errors++; $display("FAIL full_drain_valid: got %h want %h", dv_log, span(68, 75)); end
    checks++; if (dc != 76) begin errors++; $display("FAIL full_done_cycle: got %0d want 76", dc); end
    checks++; if (wr_q.size() != 0 || col_q.size() != 0) begin
      errors++; $display("FAIL full_leftover: writes=%0d columns=%0d want 0 0", wr_q.size(), col_q.size());
    end
  endtask

  task automatic test_reset_mid_drain();
    int dc;
    run_job(8'h22, 1'b0, -1, -1, 1'b0, 68, dc);
    checks++; if (dc != -1) begin errors++; $display("FAIL mrst_no_done: got done at %0d want none", dc); end
    checks++; if (bz_log !== span(1, 68))  begin errors++; $display("FAIL mrst_busy: got %h want %h", bz_log, span(1, 68)); end
    checks++; if (rd_log !== span(65, 68)) begin errors++; $display("FAIL mrst_rden: got %h want %h", rd_log, span(65, 68)); end
    checks++; if (dv_log !== span(66, 68)) begin errors++; $display("FAIL mrst_drain_valid: got %h want %h", dv_log, span(66, 68)); end
    checks++; if (ir_log !== span(1, 64))  begin errors++; $display("FAIL mrst_in_ready: got %h want %h", ir_log, span(1, 64)); end
    checks++; if (col_q.size() != 5) begin errors++; $display("FAIL mrst_columns: got %0d left want 5", col_q.size()); end
    col_q.delete();
    run_job(8'h99, 1'b0, -1, -1, 1'b0, -1, dc);
    checks++; if (dc != 74) begin errors++; $display("FAIL mrst_rerun_done: got %0d want 74", dc); end
    checks++; if (dv_log !== span(66, 73)) begin errors++; $display("FAIL mrst_rerun_dv: got %h want %h", dv_log, span(66, 73)); end
    checks++; if (wr_q.size() != 0 || col_q.size() != 0) begin
      errors++; $display("FAIL mrst_leftover: writes=%0d columns=%0d want 0 0", wr_q.size(), col_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_backpressure();
    test_spurious();
    test_full_guard();
    test_reset_mid_drain();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
